// File: rtl/systolic_output_buffer.sv
// systolic_output_buffer: frame-synchronous capture of the systolic array output into a FWFT FIFO
// Ports:
//   clk30x, reset       clock and synchronous active-high reset
//   din                 array output word, stable for a whole frame
//   dout, dout_valid    FIFO head word and its valid flag (FIFO not empty)
//   dout_ready          consumer accepts dout this cycle
//   frame_tick          one-cycle pulse after every capture edge, skipped frames included
//   fifo_level          current occupancy 0..2^DEPTH_LOG2
//   overflow            sticky, a capture was dropped at full
//   sample_count        accepted pushes, counted only when OUTBUF_STATS_EN is defined, else 0
module systolic_output_buffer #(
    parameter int WORDLENGTH   = 16,
    parameter int FRAME_LEN    = 30,
    parameter int SAMPLE_PHASE = 1,
    parameter int SKIP_FRAMES  = 8,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                  clk30x,
    input  logic                  reset,
    input  logic [WORDLENGTH-1:0] din,
    output logic [WORDLENGTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  frame_tick,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [15:0]           sample_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int SW = $clog2(SKIP_FRAMES + 2);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] PHASE = FW'(SAMPLE_PHASE);
    localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_FRAMES);
    localparam logic [0:0] ST_SKIP = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    localparam logic [0:0] ST_INIT = (SKIP_FRAMES == 0) ? ST_RUN : ST_SKIP;

    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic [SW-1:0]         skip_q, skip_d;
    logic [0:0]            state_q, state_d;
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WORDLENGTH-1:0] mem_q [DEPTH];
    logic [WORDLENGTH-1:0] mem_d [DEPTH];
    logic                  frame_tick_q, overflow_q, overflow_d;
    logic                  cap, push, pop, full, wr_en;

    always_comb begin
        cap        = fcnt_q == PHASE;
        fcnt_d     = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + 1'b1;
        skip_d     = skip_q;
        state_d    = state_q;
        if (cap && state_q == ST_SKIP) begin
            skip_d = skip_q + 1'b1;
            // the cap that completes the skip count only switches state; the next cap pushes
            state_d = (skip_d == SKIP_LAST) ? ST_RUN : ST_SKIP;
        end
        fifo_level = wr_ptr_q - rd_ptr_q;
        full       = fifo_level == (DEPTH_LOG2 + 1)'(DEPTH);
        dout_valid = fifo_level != '0;
        push       = cap && state_q == ST_RUN;
        pop        = dout_valid && dout_ready;
        // a pop in the same cycle frees the slot, so a push at full is still accepted
        wr_en      = push && (!full || pop);
        overflow_d = overflow_q || (push && full && !pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_d      = mem_q;
        if (wr_en) mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din;
        // stale storage is masked so dout reads 0 whenever the FIFO is empty
        dout       = dout_valid ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
    end

    always_ff @(posedge clk30x) begin
        if (reset) begin
            fcnt_q       <= '0;
            skip_q       <= '0;
            state_q      <= ST_INIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_tick_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            fcnt_q       <= fcnt_d;
            skip_q       <= skip_d;
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_tick_q <= cap;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk30x) mem_q <= mem_d;

    assign frame_tick = frame_tick_q;
    assign overflow   = overflow_q;

`ifdef OUTBUF_STATS_EN
    logic [15:0] count_q, count_d;

    always_comb count_d = (wr_en && !reset) ? count_q + 16'd1 : count_q;

    always_ff @(posedge clk30x) count_q <= reset ? 16'd0 : count_d;

    assign sample_count = count_q;
`else
    assign sample_count = 16'd0;
`endif
endmodule

// File: tb/tb_systolic_output_buffer.sv
// tb_systolic_output_buffer: directed self-checking bench for systolic_output_buffer
module tb_systolic_output_buffer;
    logic        clk30x = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        frame_tick;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] sample_count;

    int errors = 0;
    int checks = 0;
    int e = 0;
    int acc = 0;
`ifdef OUTBUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    systolic_output_buffer dut (
        .clk30x(clk30x), .reset(reset), .din(din), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_tick(frame_tick),
        .fifo_level(fifo_level), .overflow(overflow), .sample_count(sample_count)
    );

    always #5 clk30x = ~clk30x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk30x);
        #1;
        e++;
    endtask

    // edges are numbered from reset release; pre-edge frame count at edge e is (e-1)%30
    task automatic run_to(input int ph);
        while (e % 30 != ph) tick;
    endtask

    task automatic check_count;
        check("sample_count", sample_count, STATS ? acc : 0);
    endtask

    initial begin
        reset = 1'b1;
        din = 16'h1234;
        dout_ready = 1'b1;
        repeat (3) tick;
        check("rst_level", fifo_level, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tick", frame_tick, 0);
        check_count;
        reset = 1'b0;
        e = 0;
        // captures at edges 2, 32, ...; 8 skipped, 9th (edge 242) is the first push
        for (int i = 1; i <= 275; i++) begin
            tick;
            check("frame_tick", frame_tick, (e % 30) == 2);
            check("skip_valid", dout_valid, e >= 242 && (e % 30) == 2);
            if (dout_valid) check("skip_dout", dout, 16'h1234);
        end
        acc = 2;
        check("empty_ready_level", fifo_level, 0);
        for (int k = 1; k <= 3; k++) begin
            run_to(1);
            din = 16'(k);
            tick;
            check("run_valid", dout_valid, 1);
            check("run_dout", dout, k);
            check("run_level1", fifo_level, 1);
            tick;
            check("run_valid_off", dout_valid, 0);
            check("run_level0", fifo_level, 0);
            acc++;
        end
        dout_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            run_to(1);
            din = 16'(16'h100 + k);
            tick;
            if (k <= 8) acc++;
            check("fill_level", fifo_level, k < 8 ? k : 8);
            check("fill_overflow", overflow, k > 8);
            check("fill_head", dout, 16'h101);
        end
        dout_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            check("drain_valid", dout_valid, 1);
            check("drain_dout", dout, 16'h100 + j);
            tick;
        end
        check("drain_empty", dout_valid, 0);
        check("drain_overflow", overflow, 1);
        dout_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            run_to(1);
            din = 16'(16'h400 + k);
            tick;
            acc++;
        end
        check("pre_rst_level", fifo_level, 5);
        check_count;
        run_to(15);
        reset = 1'b1;
        tick;
        acc = 0;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_dout", dout, 0);
        check_count;
        reset = 1'b0;
        e = 0;
        din = 16'h200;
        for (int i = 1; i <= 242; i++) begin
            tick;
            check("reskip_valid", dout_valid, e >= 242);
        end
        acc = 1;
        check("reskip_dout", dout, 16'h200);
        for (int k = 2; k <= 8; k++) begin
            run_to(1);
            din = 16'(16'h200 + k);
            tick;
            acc++;
        end
        check("full_level", fifo_level, 8);
        check("full_overflow", overflow, 0);
        run_to(1);
        din = 16'h209;
        dout_ready = 1'b1;
        tick;
        dout_ready = 1'b0;
        acc++;
        check("pushpop_level", fifo_level, 8);
        check("pushpop_overflow", overflow, 0);
        check("pushpop_head", dout, 16'h202);
        check_count;
        dout_ready = 1'b1;
        for (int j = 2; j <= 9; j++) begin
            check("tail_dout", dout, 16'h200 + j);
            tick;
        end
        check("tail_empty", dout_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
